// File: rtl/bram_scan_reader.sv
// Read-side sequencer for a registered-read block RAM: sweeps a wrap-around
// address range, streams words through a 2-entry buffer and sums them.
module bram_scan_reader #(
   parameter int WID_MEM   = 3,
   parameter int DEPTH_MEM = 1024,
   parameter int ADDR_W    = 10,
   parameter int CSUM_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W:0]   count,
   output logic [ADDR_W-1:0] raddr,
   input  logic [WID_MEM-1:0] mem_dout,
   output logic [WID_MEM-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done,
   output logic [CSUM_W-1:0] checksum
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_DRAIN
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_MEM - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

   state_t              r_state;
   logic [ADDR_W-1:0]   r_raddr;
   logic [ADDR_W-1:0]   r_pend_addr;
   logic [ADDR_W:0]     r_count;
   logic [ADDR_W:0]     r_issued;
   logic                r_pending;
   logic [WID_MEM-1:0]  r_buf_data [2];
   logic [ADDR_W-1:0]   r_buf_addr [2];
   logic                r_wptr;
   logic                r_rptr;
   logic [1:0]          r_occ;
   logic                r_busy;
   logic                r_done;
   logic [CSUM_W-1:0]   r_csum;

   logic                w_accept;
   logic                w_issue;
   logic                w_last_issue;
   logic                w_drained;
   logic [2:0]          w_load;
   logic [ADDR_W-1:0]   w_next_addr;

   // Slot budget counts the word leaving this cycle, so a full buffer
   // re-issues on the same edge it is drained and ready=1 sustains 1 word/cycle.
   always_comb begin
      w_accept     = (r_occ != 2'd0) && out_ready;
      w_load       = {2'b00, r_pending} + {1'b0, r_occ} - {2'b00, w_accept};
      w_issue      = (r_state == ST_SCAN) && (w_load < 3'd2);
      w_last_issue = w_issue && ((r_issued + CNT_ONE) == r_count);
      w_drained    = !r_pending && ((r_occ == 2'd0) || ((r_occ == 2'd1) && w_accept));
      w_next_addr  = (r_raddr == LAST_ADDR) ? '0 : r_raddr + ADDR_ONE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_raddr     <= '0;
         r_pend_addr <= '0;
         r_count     <= '0;
         r_issued    <= '0;
         r_pending   <= 1'b0;
         r_wptr      <= 1'b0;
         r_rptr      <= 1'b0;
         r_occ       <= 2'd0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_csum      <= '0;
         for (int unsigned i = 0; i < 2; i++) begin
            r_buf_data[i] <= '0;
            r_buf_addr[i] <= '0;
         end
      end else begin
         r_done    <= 1'b0;
         r_pending <= w_issue;
         if (w_issue) begin
            r_pend_addr <= r_raddr;
            r_raddr     <= w_next_addr;
            r_issued    <= r_issued + CNT_ONE;
         end
         if (r_pending) begin
            r_buf_data[r_wptr] <= mem_dout;
            r_buf_addr[r_wptr] <= r_pend_addr;
            r_wptr             <= ~r_wptr;
         end
         if (w_accept) begin
            r_rptr <= ~r_rptr;
            r_csum <= r_csum + CSUM_W'(r_buf_data[r_rptr]);
         end
         r_occ <= r_occ + {1'b0, r_pending} - {1'b0, w_accept};

         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_raddr  <= start_addr;
                  r_count  <= count;
                  r_issued <= '0;
                  r_csum   <= '0;
                  if (count == '0) begin
                     r_done <= 1'b1;
                  end else begin
                     r_state <= ST_SCAN;
                     r_busy  <= 1'b1;
                  end
               end
            end
            ST_SCAN: begin
               if (w_last_issue) begin
                  r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (w_drained) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign raddr     = r_raddr;
   assign out_data  = r_buf_data[r_rptr];
   assign out_addr  = r_buf_addr[r_rptr];
   assign out_valid = (r_occ != 2'd0);
   assign busy      = r_busy;
   assign done      = r_done;
   assign checksum  = r_csum;

endmodule

// File: tb/tb_bram_scan_reader.sv
// Bench for bram_scan_reader: registered-read RAM holding i mod 8, an
// expected-stream model checked every cycle, plus literal scenario checks.
module tb_bram_scan_reader;

   localparam int AW = 10;
   localparam int DW = 3;
   localparam int CW = 16;

   logic          clk;
   logic          reset;
   logic          start;
   logic [AW-1:0] start_addr;
   logic [AW:0]   count;
   logic [AW-1:0] raddr;
   logic [DW-1:0] mem_dout;
   logic [DW-1:0] out_data;
   logic [AW-1:0] out_addr;
   logic          out_valid;
   logic          out_ready;
   logic          busy;
   logic          done;
   logic [CW-1:0] checksum;

   bram_scan_reader #(
      .WID_MEM  (DW),
      .DEPTH_MEM(1024),
      .ADDR_W   (AW),
      .CSUM_W   (CW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .start_addr(start_addr),
      .count     (count),
      .raddr     (raddr),
      .mem_dout  (mem_dout),
      .out_data  (out_data),
      .out_addr  (out_addr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done),
      .checksum  (checksum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [DW-1:0] ram [1024];
   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = DW'(i % 8);
      mem_dout = '0;
   end
   always @(posedge clk) mem_dout <= ram[raddr];

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } word_t;

   word_t         exp_q [$];
   word_t         log_q [$];
   int            total = 0;
   int            bad = 0;
   logic [CW-1:0] m_csum = '0;
   bit            chk_en = 1'b0;
   bit            prev_stall = 1'b0;
   word_t         prev_w;
   int            n_acc = 0;
   logic [7:0]    pat = 8'b01101001;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en && reset) begin
         chk("checksum_track", 32'(checksum), 32'(m_csum));
         chk("done_with_valid", 32'(done && out_valid), 32'd0);
         if (prev_stall) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'(prev_w.d));
            chk("stall_addr", 32'(out_addr), 32'(prev_w.a));
         end
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_valid", 32'(out_valid), 32'd0);
            end else begin
               chk("stream_addr", 32'(out_addr), 32'(exp_q[0].a));
               chk("stream_data", 32'(out_data), 32'(exp_q[0].d));
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  log_q.push_back('{a: out_addr, d: out_data});
                  m_csum = m_csum + CW'(out_data);
                  n_acc++;
               end
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_w     = '{a: out_addr, d: out_data};
      end
   end

   task automatic check_reset_vals(input string tag);
      chk({tag, "_raddr"}, 32'(raddr), 32'd0);
      chk({tag, "_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_data"}, 32'(out_data), 32'd0);
      chk({tag, "_addr"}, 32'(out_addr), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_csum"}, 32'(checksum), 32'd0);
   endtask

   // Pulses start for one edge and loads the expected stream from the address rule.
   task automatic kick(input int sa, input int cnt);
      @(posedge clk); #1;
      start      = 1'b1;
      start_addr = AW'(sa);
      count      = (AW + 1)'(cnt);
      out_ready  = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      m_csum = '0;
      log_q.delete();
      for (int i = 0; i < cnt; i++) begin
         word_t w;
         w.a = AW'((sa + i) % 1024);
         w.d = DW'(((sa + i) % 1024) % 8);
         exp_q.push_back(w);
      end
   endtask

   task automatic run_scan(input int sa, input int cnt, input int mode, input int ign_k,
                           input int exp_csum, input string tag);
      int k;
      int first_v;
      k = 0;
      first_v = -1;
      kick(sa, cnt);
      while (k < 4000) begin
         out_ready = (mode == 0) ? 1'b1 : pat[k % 8];
         if (k == ign_k) begin
            start      = 1'b1;
            start_addr = AW'(500);
            count      = (AW + 1)'(7);
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         if (k == 0) chk({tag, "_busy_first"}, 32'(busy), (cnt != 0) ? 32'd1 : 32'd0);
         if (out_valid && first_v < 0) first_v = k;
         if (done) break;
         @(posedge clk); #1;
         k++;
      end
      start = 1'b0;
      if (k >= 4000) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
      if (mode == 0) begin
         chk({tag, "_done_cycle"}, 32'(k), (cnt == 0) ? 32'd0 : 32'(cnt + 2));
         if (cnt != 0) chk({tag, "_first_valid"}, 32'(first_v), 32'd2);
      end
      if (cnt == 0) chk({tag, "_no_valid"}, 32'(first_v), 32'hFFFF_FFFF);
      chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      chk({tag, "_csum"}, 32'(checksum), 32'(exp_csum));
      chk({tag, "_remaining"}, 32'(exp_q.size()), 32'd0);
      chk({tag, "_accepted"}, 32'(log_q.size()), 32'(cnt));
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
      chk({tag, "_csum_hold"}, 32'(checksum), 32'(exp_csum));
   endtask

   int wrap_a [4] = '{1022, 1023, 0, 1};
   int wrap_d [4] = '{6, 7, 0, 1};
   int bp_d   [8] = '{5, 6, 7, 0, 1, 2, 3, 4};

   initial begin
      int base;
      int guard;
      reset      = 1'b1;
      start      = 1'b0;
      start_addr = '0;
      count      = '0;
      out_ready  = 1'b1;
      #2 reset = 1'b0;
      #1 check_reset_vals("por");
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      chk_en = 1'b1;

      run_scan(0, 1024, 0, -1, 16'h0E00, "full");
      chk("full_first_addr", 32'(log_q[0].a), 32'd0);
      chk("full_last_addr", 32'(log_q[1023].a), 32'd1023);
      chk("full_last_data", 32'(log_q[1023].d), 32'd7);

      run_scan(1022, 4, 0, -1, 14, "wrap");
      for (int i = 0; i < 4; i++) begin
         chk("wrap_lit_addr", 32'(log_q[i].a), 32'(wrap_a[i]));
         chk("wrap_lit_data", 32'(log_q[i].d), 32'(wrap_d[i]));
      end

      run_scan(5, 8, 1, -1, 28, "bp");
      for (int i = 0; i < 8; i++) chk("bp_lit_data", 32'(log_q[i].d), 32'(bp_d[i]));

      run_scan(0, 0, 0, -1, 0, "zero");

      base = n_acc;
      kick(0, 100);
      guard = 0;
      while ((n_acc - base) < 10 && guard < 500) begin
         @(posedge clk);
         guard++;
      end
      chk("rst_reached_10", 32'(n_acc - base >= 10), 32'd1);
      #1 reset = 1'b0;
      chk_en = 1'b0;
      #1 check_reset_vals("midrst");
      exp_q.delete();
      m_csum     = '0;
      prev_stall = 1'b0;
      @(posedge clk); #1;
      check_reset_vals("midrst_hold");
      reset  = 1'b1;
      chk_en = 1'b1;
      run_scan(0, 2, 0, -1, 1, "after_rst");
      chk("after_rst_d0", 32'(log_q[0].d), 32'd0);
      chk("after_rst_d1", 32'(log_q[1].d), 32'd1);

      run_scan(0, 16, 0, 5, 56, "ign");
      chk("ign_first_addr", 32'(log_q[0].a), 32'd0);
      chk("ign_last_addr", 32'(log_q[15].a), 32'd15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
